// File: rtl/max_counter_sampler.sv
// max_counter_sampler: snapshot reader for a max-tracking up/down counter.
// Captures value/max/overflow on a timer or trigger, pulses clear_max_o and
// buffers samples in a 2-entry FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   clear_i              sync clear of queue, timer, seq, lost flag, drops
//   en_i, trigger_i      sampling enable, manual one-cycle snapshot request
//   period_i             auto-sample interval in cycles (0 = timer off)
//   q_i, max_i,
//   overflow_max_i       live counter value, high-water mark, max overflow
//   clear_max_o          combinational clear-max pulse in the capture cycle
//   valid_o, ready_i     sample handshake
//   sample_*_o           head-of-queue sample fields
//   dropped_o            saturating count of dropped snapshots
module max_counter_sampler #(
    parameter int WIDTH        = 4,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    trigger_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0]        q_i,
    input  logic [WIDTH-1:0]        max_i,
    input  logic                    overflow_max_i,
    output logic                    clear_max_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [WIDTH-1:0]        sample_q_o,
    output logic [WIDTH-1:0]        sample_max_o,
    output logic                    sample_ovf_o,
    output logic [7:0]              sample_seq_o,
    output logic                    sample_lost_o,
    output logic [7:0]              dropped_o
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_FINAL
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] mx;
        logic             ovf;
        logic [7:0]       seq;
        logic             lost;
    } sample_t;

    localparam logic [PERIOD_WIDTH-1:0] PONE = PERIOD_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic [7:0]              seq_q, seq_d;
    logic                    lost_q, lost_d;
    logic [7:0]              dropped_q, dropped_d;
    logic [1:0]              count_q, count_d;
    logic                    rd_ptr_q, rd_ptr_d;
    sample_t                 mem_q [2];

    logic    due;
    logic    take;
    logic    drop;
    logic    pop;
    logic    full;
    logic    period_hit;
    logic    wr_idx;
    sample_t new_sample;

    assign full = (count_q == 2'd2);
    assign pop  = (count_q != 2'd0) && ready_i;

    // >= rather than == so a shrinking period fires at once.
    assign period_hit = (period_i != '0) && (timer_q >= (period_i - PONE));

    // Write slot follows the head by the fill level; at full with a pop
    // this lands on the slot being vacated this cycle.
    assign wr_idx = rd_ptr_q ^ count_q[0];

    assign new_sample = '{
        q:    q_i,
        mx:   max_i,
        ovf:  overflow_max_i,
        seq:  seq_q,
        lost: lost_q
    };

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        seq_d     = seq_q;
        lost_d    = lost_q;
        dropped_d = dropped_q;
        due       = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                timer_d = '0;
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                due     = trigger_i || period_hit;
                timer_d = due ? '0 : timer_q + PONE;
                if (!en_i) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                // Final capture waits for space; it is never dropped.
                due     = 1'b1;
                timer_d = '0;
            end
            default: begin
                state_d = ST_OFF;
                timer_d = '0;
            end
        endcase

        if (clear_i) begin
            due = 1'b0;
        end

        take = due && (!full || pop);
        drop = due && !take && (state_q == ST_RUN);

        if (take) begin
            seq_d  = seq_q + 8'd1;
            lost_d = 1'b0;
            if (state_q == ST_FINAL) begin
                state_d = ST_OFF;
            end
        end

        if (drop) begin
            lost_d = 1'b1;
            if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end
        end

        if (clear_i) begin
            state_d   = en_i ? ST_RUN : ST_OFF;
            timer_d   = '0;
            seq_d     = '0;
            lost_d    = 1'b0;
            dropped_d = '0;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        unique case ({take, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (clear_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            timer_q   <= '0;
            seq_q     <= '0;
            lost_q    <= 1'b0;
            dropped_q <= '0;
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_q     <= seq_d;
            lost_q    <= lost_d;
            dropped_q <= dropped_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            if (take) begin
                mem_q[wr_idx] <= new_sample;
            end
        end
    end

    assign clear_max_o   = take;
    assign valid_o       = (count_q != 2'd0);
    assign sample_q_o    = mem_q[rd_ptr_q].q;
    assign sample_max_o  = mem_q[rd_ptr_q].mx;
    assign sample_ovf_o  = mem_q[rd_ptr_q].ovf;
    assign sample_seq_o  = mem_q[rd_ptr_q].seq;
    assign sample_lost_o = mem_q[rd_ptr_q].lost;
    assign dropped_o     = dropped_q;

endmodule

// File: tb/tb_max_counter_sampler.sv
// tb_max_counter_sampler: directed self-checking bench for
// max_counter_sampler.
module tb_max_counter_sampler;

    logic        clk_i;
    logic        rst_i;
    logic        clear_i;
    logic        en_i;
    logic        trigger_i;
    logic [15:0] period_i;
    logic [3:0]  q_i;
    logic [3:0]  max_i;
    logic        overflow_max_i;
    logic        clear_max_o;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  sample_q_o;
    logic [3:0]  sample_max_o;
    logic        sample_ovf_o;
    logic [7:0]  sample_seq_o;
    logic        sample_lost_o;
    logic [7:0]  dropped_o;

    int checks = 0;
    int errors = 0;

    max_counter_sampler #(
        .WIDTH        (4),
        .PERIOD_WIDTH (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .en_i           (en_i),
        .trigger_i      (trigger_i),
        .period_i       (period_i),
        .q_i            (q_i),
        .max_i          (max_i),
        .overflow_max_i (overflow_max_i),
        .clear_max_o    (clear_max_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .sample_q_o     (sample_q_o),
        .sample_max_o   (sample_max_o),
        .sample_ovf_o   (sample_ovf_o),
        .sample_seq_o   (sample_seq_o),
        .sample_lost_o  (sample_lost_o),
        .dropped_o      (dropped_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i          = 1'b1;
        clear_i        = 1'b0;
        en_i           = 1'b0;
        trigger_i      = 1'b0;
        period_i       = 16'd0;
        q_i            = 4'd0;
        max_i          = 4'd0;
        overflow_max_i = 1'b0;
        ready_i        = 1'b0;
        #12;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_cm", 32'(clear_max_o), 32'd0);
        chk("rst_q", 32'(sample_q_o), 32'd0);
        chk("rst_seq", 32'(sample_seq_o), 32'd0);
        chk("rst_drop", 32'(dropped_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Periodic sampling, period 4
        en_i     = 1'b1;
        period_i = 16'd4;
        ready_i  = 1'b1;
        q_i      = 4'd3;
        max_i    = 4'd5;
        #1 chk("off_cm", 32'(clear_max_o), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                #1 chk("per_idle_cm", 32'(clear_max_o), 32'd0);
                tick();
            end
            #1 chk("per_cm", 32'(clear_max_o), 32'd1);
            tick();
            chk("per_valid", 32'(valid_o), 32'd1);
            chk("per_seq", 32'(sample_seq_o), 32'(k));
            chk("per_q", 32'(sample_q_o), 32'd3);
            chk("per_max", 32'(sample_max_o), 32'd5);
        end
        period_i = 16'd0;
        clear_i  = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_valid", 32'(valid_o), 32'd0);

        // Backpressure drop
        ready_i   = 1'b0;
        trigger_i = 1'b1;
        #1 chk("bp_cm0", 32'(clear_max_o), 32'd1);
        tick();
        chk("bp_seq0", 32'(sample_seq_o), 32'd0);
        #1 chk("bp_cm1", 32'(clear_max_o), 32'd1);
        tick();
        #1 chk("bp_cm_drop", 32'(clear_max_o), 32'd0);
        tick();
        trigger_i = 1'b0;
        chk("bp_dropped", 32'(dropped_o), 32'd1);
        chk("bp_head0", 32'(sample_seq_o), 32'd0);
        max_i   = 4'd9;
        ready_i = 1'b1;
        tick();
        ready_i   = 1'b0;
        trigger_i = 1'b1;
        chk("bp_head1", 32'(sample_seq_o), 32'd1);
        chk("bp_lost1", 32'(sample_lost_o), 32'd0);
        #1 chk("bp_cm3", 32'(clear_max_o), 32'd1);
        tick();
        trigger_i = 1'b0;
        ready_i   = 1'b1;
        tick();
        chk("bp_seq2", 32'(sample_seq_o), 32'd2);
        chk("bp_lost2", 32'(sample_lost_o), 32'd1);
        chk("bp_max2", 32'(sample_max_o), 32'd9);
        tick();
        chk("bp_empty", 32'(valid_o), 32'd0);

        // Trigger coincident with timer expiry
        clear_i  = 1'b1;
        period_i = 16'd3;
        tick();
        clear_i = 1'b0;
        tick();
        tick();
        trigger_i = 1'b1;
        #1 chk("co_cm", 32'(clear_max_o), 32'd1);
        tick();
        trigger_i = 1'b0;
        chk("co_seq0", 32'(sample_seq_o), 32'd0);
        tick();
        chk("co_single", 32'(valid_o), 32'd0);
        tick();
        #1 chk("co_cm2", 32'(clear_max_o), 32'd1);
        tick();
        chk("co_seq1", 32'(sample_seq_o), 32'd1);
        period_i = 16'd0;
        tick();

        // Full queue with pop in the same cycle
        ready_i   = 1'b0;
        trigger_i = 1'b1;
        tick();
        tick();
        ready_i = 1'b1;
        #1 chk("fp_cm", 32'(clear_max_o), 32'd1);
        tick();
        trigger_i = 1'b0;
        chk("fp_dropped", 32'(dropped_o), 32'd0);
        chk("fp_seq3", 32'(sample_seq_o), 32'd3);
        tick();
        chk("fp_seq4", 32'(sample_seq_o), 32'd4);
        tick();
        chk("fp_empty", 32'(valid_o), 32'd0);

        // Disable flush with full queue
        ready_i   = 1'b0;
        trigger_i = 1'b1;
        tick();
        tick();
        trigger_i = 1'b0;
        en_i      = 1'b0;
        tick();
        #1 chk("fin_wait0", 32'(clear_max_o), 32'd0);
        tick();
        #1 chk("fin_wait1", 32'(clear_max_o), 32'd0);
        chk("fin_head", 32'(sample_seq_o), 32'd5);
        tick();
        ready_i        = 1'b1;
        overflow_max_i = 1'b1;
        trigger_i      = 1'b1;
        #1 chk("fin_cm", 32'(clear_max_o), 32'd1);
        tick();
        overflow_max_i = 1'b0;
        #1 chk("off_trig0", 32'(clear_max_o), 32'd0);
        chk("fin_seq6", 32'(sample_seq_o), 32'd6);
        tick();
        #1 chk("off_trig1", 32'(clear_max_o), 32'd0);
        chk("fin_seq7", 32'(sample_seq_o), 32'd7);
        chk("fin_ovf", 32'(sample_ovf_o), 32'd1);
        tick();
        trigger_i = 1'b0;
        chk("fin_empty", 32'(valid_o), 32'd0);

        // Drop count saturation
        en_i    = 1'b1;
        clear_i = 1'b1;
        ready_i = 1'b0;
        tick();
        clear_i   = 1'b0;
        trigger_i = 1'b1;
        repeat (100) tick();
        chk("sat_mid", 32'(dropped_o), 32'd98);
        repeat (202) tick();
        chk("sat_full", 32'(dropped_o), 32'd255);
        trigger_i = 1'b0;

        // Sequence wrap at period 1
        clear_i  = 1'b1;
        period_i = 16'd1;
        ready_i  = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        chk("wrap_first", 32'(sample_seq_o), 32'd0);
        chk("wrap_drop0", 32'(dropped_o), 32'd0);
        repeat (255) tick();
        chk("wrap_255", 32'(sample_seq_o), 32'd255);
        tick();
        chk("wrap_0", 32'(sample_seq_o), 32'd0);

        // Clear with full queue
        period_i = 16'd0;
        ready_i  = 1'b0;
        clear_i  = 1'b1;
        tick();
        clear_i   = 1'b0;
        trigger_i = 1'b1;
        repeat (3) tick();
        chk("clr_pre_drop", 32'(dropped_o), 32'd1);
        clear_i = 1'b1;
        #1 chk("clr_cm", 32'(clear_max_o), 32'd0);
        tick();
        clear_i   = 1'b0;
        trigger_i = 1'b0;
        chk("clr_empty", 32'(valid_o), 32'd0);
        chk("clr_drop", 32'(dropped_o), 32'd0);

        // Asynchronous reset mid-run
        trigger_i = 1'b1;
        repeat (3) tick();
        chk("mr_valid_pre", 32'(valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("mr_valid", 32'(valid_o), 32'd0);
        chk("mr_cm", 32'(clear_max_o), 32'd0);
        chk("mr_q", 32'(sample_q_o), 32'd0);
        chk("mr_max", 32'(sample_max_o), 32'd0);
        chk("mr_drop", 32'(dropped_o), 32'd0);
        trigger_i = 1'b0;
        rst_i     = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_counter_sampler.md
# max_counter_sampler

Snapshot reader for a max-tracking up/down counter. It periodically or on demand captures the counter's current value, high-water mark and max-overflow flag, then issues the matching `clear_max` pulse. Captured samples are buffered in a 2-entry queue and handed to a telemetry or CSR consumer over a valid/ready interface. It sits between a max-tracking counter instance and the statistics readout path.

## Interface
- `WIDTH`, 4: counter, max and snapshot value width.
- `PERIOD_WIDTH`, 16: width of the sample-interval timer and `period_i`.
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `clear_i`  in  1  synchronous clear of queue, timer, sequence number and drop count.
- `en_i`  in  1  sampling enable.
- `trigger_i`  in  1  manual snapshot request, single-cycle.
- `period_i`  in  PERIOD_WIDTH  auto-sample interval in cycles; 0 disables the auto timer.
- `q_i`  in  WIDTH  counter value.
- `max_i`  in  WIDTH  counter high-water mark, combinational max output of the counter.
- `overflow_max_i`  in  1  counter max-overflow flag.
- `clear_max_o`  out  1  clear-max pulse to the counter, combinational, asserted in the capture cycle only.
- `valid_o`  out  1  sample available.
- `ready_i`  in  1  consumer accepts the sample.
- `sample_q_o`  out  WIDTH  captured `q_i`.
- `sample_max_o`  out  WIDTH  captured `max_i`.
- `sample_ovf_o`  out  1  captured `overflow_max_i`.
- `sample_seq_o`  out  8  sequence number of the sample, wraps 255 -> 0.
- `sample_lost_o`  out  1  one or more snapshots were dropped since the previous enqueued sample.
- `dropped_o`  out  8  saturating count of dropped snapshots.

## Operation
- **FSM states:** OFF, RUN, FINAL. Reset state is OFF.
- **OFF:**
  - Goes to RUN when `en_i`=1.
  - Timer is held at 0.
  - No captures; `trigger_i` is ignored.
- **RUN:** a capture is due when either condition holds:
  - `trigger_i`=1; or
  - `period_i`!=0 and timer >= `period_i`-1.
- **RUN timer:**
  - Increments each cycle.
  - Resets to 0 on any due capture, whether it is taken or dropped.
  - The `>=` comparison makes a mid-run reduction of `period_i` fire immediately.
- **RUN, trigger and timer coincide:** exactly one capture is taken.
- **RUN to FINAL:** when `en_i`=0.
- **FINAL:**
  - Takes one capture as soon as the queue has space, waiting as long as needed.
  - Then goes to OFF.
  - `trigger_i` and the timer are ignored.
  - If `en_i` returns to 1 while waiting, the final capture still completes, then the FSM goes to OFF and then to RUN.
- **Capture taken (queue not full, or full with a pop in the same cycle):**
  - Enqueue {`q_i`, `max_i`, `overflow_max_i`, seq, lost}.
  - Assert `clear_max_o`.
  - seq increments; the lost flag clears.
- **Capture due with queue full and no pop:**
  - Sample dropped.
  - `clear_max_o` is NOT asserted, so the counter's max keeps accumulating into the next sample.
  - `dropped_o` increments, saturating at 255.
  - The lost flag is set; seq does not advance.
- **Queue:**
  - 2 entries, FIFO order.
  - Pop when `valid_o` && `ready_i`.
  - Simultaneous push and pop is allowed at any fill level.
- **`clear_i`:**
  - Empties the queue.
  - Zeroes timer, seq, lost flag and `dropped_o`.
  - Sets state to RUN if `en_i`=1, else OFF.
  - No capture in that cycle; `clear_max_o`=0.

## Timing
- **Reset values:** `valid_o`=0, `clear_max_o`=0, all sample outputs 0, `dropped_o`=0, seq=0, state OFF.
- **Mid-operation reset:** asynchronous assertion immediately forces these reset values; queued samples are lost.
- **Capture-to-valid latency:** a capture in cycle n with an empty queue gives `valid_o`=1 in cycle n+1.
- **Handshake:** once `valid_o` rises it stays high, with all sample fields stable, until accepted. No combinational path from `ready_i` to `valid_o`.
- **`clear_max_o`:** same-cycle combinational from the capture decision. The counter's max resets at the following edge, so the captured max and the cleared max refer to the same boundary and no update is lost.
- **First auto sample:** the first auto capture after entering RUN occurs `period_i` cycles after entry. Period P yields one capture every P cycles; P=1 captures every cycle.
- **Drop accounting:** `dropped_o` updates at the edge after the dropped capture.

## Test plan
- **Periodic sampling:** `period_i`=4, `en_i`=1, `ready_i`=1, counter at q=3/max=5 → a capture every 4 cycles, each with `clear_max_o` pulsing 1 cycle, `valid_o` next cycle, and seq 0,1,2…
- **Backpressure drop:** `ready_i`=0, three triggers → 2 samples queued (seq 0,1) and `dropped_o`=1. The third `clear_max_o` is absent. Raise `ready_i` then trigger → seq 2 with `sample_lost_o`=1, carrying the accumulated max.
- **Simultaneous events:** trigger coincident with timer expiry → one sample and one `clear_max_o`. Queue full with a pop in the same cycle → capture accepted, not dropped.
- **Disable flush:** `en_i` falls with the queue full and `ready_i`=0 → FSM holds in FINAL. Set `ready_i`=1 → one final capture, then OFF, with no further captures despite triggers.
- **Saturation and wrap:** 300 dropped captures → `dropped_o`=255. 257 accepted captures → seq wraps to 0 at the 257th.
- **Reset and clear:** assert `rst_i` mid-run with 2 samples queued → `valid_o`=0 immediately, all outputs 0. `clear_i` with queue full → empty next cycle and `dropped_o`=0.
